main_memory_model: RTL and testbench

//  Block-granular main-memory responder sitting directly downstream of cache_controller.

---
 rtl/cache_mem_pkg.sv | 21 ++
 rtl/mem_block_ram.sv | 30 +++
 rtl/main_memory_model.sv | 117 +++++++++++
 tb/tb_main_memory_model.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and default widths for the cache-to-memory interface.
package cache_mem_pkg;

  localparam int MEM_WORD_WIDTH  = 32;
  localparam int MEM_BLOCK_WIDTH = 4 * MEM_WORD_WIDTH;
  localparam int MEM_BLK_ADDR_W  = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2,
    RESP    = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [MEM_BLK_ADDR_W-1:0]  addr;
    logic [MEM_BLOCK_WIDTH-1:0] data;
    logic                       is_write;
  } mem_req_t;

endpackage

// File: rtl/mem_block_ram.sv
// Single-port line array with synchronous write and registered, hold-on-idle read port.
module mem_block_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read register only updates on a read, so the line stays put while the cache stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_model.sv
// Block-granular memory responder: fixed-latency write-back and refill behind valid/ready.
module main_memory_model
  import cache_mem_pkg::*;
#(
  parameter int BLK_ADDR_W  = MEM_BLK_ADDR_W,
  parameter int BLOCK_WIDTH = MEM_BLOCK_WIDTH,
  parameter int LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_cache,
  output logic                   ready_mem,
  input  logic                   read_en_mem,
  input  logic                   write_en_mem,
  input  logic [BLK_ADDR_W-1:0]  addr_mem,
  input  logic [BLOCK_WIDTH-1:0] wdata_mem,
  output logic                   valid_mem,
  input  logic                   ready_cache,
  output logic [BLOCK_WIDTH-1:0] rdata_mem,
  output logic                   req_err
);

  typedef struct packed {
    logic [BLK_ADDR_W-1:0]  addr;
    logic [BLOCK_WIDTH-1:0] data;
    logic                   is_write;
  } req_t;

  mem_state_e state_q;
  req_t       req_q;
  logic [3:0] cnt_q;
  logic       ready_q;
  logic       valid_q;
  logic       err_q;
  logic       done;
  logic       ram_we;
  logic       ram_re;

  // Array access is issued on the completion edge itself; rst suppresses it so an
  // aborted write never lands and an aborted refill never loads the read register.
  always_comb begin
    done   = (state_q == BUSY_WR || state_q == BUSY_RD) && (cnt_q == 4'd0);
    ram_we = done && req_q.is_write && !rst;
    ram_re = done && !req_q.is_write && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_cache && ready_q) begin
            if (read_en_mem || write_en_mem) begin
              req_q.addr     <= addr_mem;
              req_q.data     <= wdata_mem;
              req_q.is_write <= write_en_mem;
              cnt_q          <= 4'(LATENCY - 1);
              ready_q        <= 1'b0;
              err_q          <= read_en_mem && write_en_mem;
              state_q        <= write_en_mem ? BUSY_WR : BUSY_RD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        BUSY_WR: begin
          if (cnt_q == 4'd0) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        BUSY_RD: begin
          if (cnt_q == 4'd0) begin
            valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (ready_cache) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_block_ram #(
    .ADDR_W(BLK_ADDR_W),
    .DATA_W(BLOCK_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (req_q.addr),
    .wdata_i(req_q.data),
    .rdata_o(rdata_mem)
  );

  assign ready_mem = ready_q;
  assign valid_mem = valid_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_main_memory_model.sv
// Directed, table-driven bench for main_memory_model at default parameters (LATENCY=4).
module tb_main_memory_model;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_cache = 1'b0;
  logic         ready_mem;
  logic         read_en_mem = 1'b0;
  logic         write_en_mem = 1'b0;
  logic [9:0]   addr_mem = '0;
  logic [127:0] wdata_mem = '0;
  logic         valid_mem;
  logic         ready_cache = 1'b0;
  logic [127:0] rdata_mem;
  logic         req_err;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;
  localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] D2 = 128'hFFFF_0000_A5A5_5A5A_0F0F_F0F0_8001_7FFE;
  localparam logic [127:0] D3 = 128'h1357_9BDF_2468_ACE0_0102_0304_0506_0708;
  localparam logic [127:0] DA = 128'hAAAA_AAAA_5555_5555_AAAA_AAAA_5555_5555;
  localparam logic [127:0] DB = 128'hBBBB_BBBB_CCCC_CCCC_DDDD_DDDD_EEEE_EEEE;

  main_memory_model #(
    .BLK_ADDR_W (10),
    .BLOCK_WIDTH(128),
    .LATENCY    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_cache (valid_cache),
    .ready_mem   (ready_mem),
    .read_en_mem (read_en_mem),
    .write_en_mem(write_en_mem),
    .addr_mem    (addr_mem),
    .wdata_mem   (wdata_mem),
    .valid_mem   (valid_mem),
    .ready_cache (ready_cache),
    .rdata_mem   (rdata_mem),
    .req_err     (req_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         v;
    logic         rd;
    logic         wr;
    logic [9:0]   addr;
    logic [127:0] wd;
    logic         rc;
    logic         e_ready;
    logic         e_valid;
    logic [127:0] e_rdata;
    logic         e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic rd, input logic wr,
                     input logic [9:0] a, input logic [127:0] wd, input logic rc,
                     input logic er, input logic ev, input logic [127:0] erd,
                     input logic eerr);
    vec_t x;
    x.rst = r; x.v = v; x.rd = rd; x.wr = wr; x.addr = a; x.wd = wd; x.rc = rc;
    x.e_ready = er; x.e_valid = ev; x.e_rdata = erd; x.e_err = eerr;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1ns after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic rd, input logic wr,
                     input logic [9:0] a, input logic [127:0] wd, input logic rc);
    @(negedge clk);
    rst = r; valid_cache = v; read_en_mem = rd; write_en_mem = wr;
    addr_mem = a; wdata_mem = wd; ready_cache = rc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rc);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, '0, rc);
  endtask

  initial begin
    int n;

    // Reset
    add(1,0,0,0,10'h000,'0,0, 1,0,'0,0);
    add(1,0,0,0,10'h000,'0,0, 1,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 1,0,'0,0);
    // Write-back 0x005: ready low for exactly 4 cycles
    add(0,1,0,1,10'h005,D1,0, 0,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 1,0,'0,0);
    // Refill 0x005, a write request while busy must be ignored, then 3-cycle stall
    add(0,1,1,0,10'h005,'0,0, 0,0,'0,0);
    add(0,1,0,1,10'h005,D3,0, 0,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,'0,0);
    add(0,0,0,0,10'h000,'0,0, 0,1,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,1,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,1,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,1,D1,0);
    add(0,0,0,0,10'h000,'0,1, 1,0,D1,0);
    // Seed 0x000
    add(0,1,0,1,10'h000,D0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,0, 1,0,D1,0);
    // Dirty miss: write 0x3FF, refill 0x000 held on the bus throughout
    add(0,1,0,1,10'h3FF,D2,0, 0,0,D1,0);
    add(0,1,1,0,10'h000,'0,0, 0,0,D1,0);
    add(0,1,1,0,10'h000,'0,0, 0,0,D1,0);
    add(0,1,1,0,10'h000,'0,0, 0,0,D1,0);
    add(0,1,1,0,10'h000,'0,0, 1,0,D1,0);
    add(0,1,1,0,10'h000,'0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D1,0);
    add(0,0,0,0,10'h000,'0,1, 0,1,D0,0);
    add(0,0,0,0,10'h000,'0,1, 1,0,D0,0);
    // Re-read 0x3FF
    add(0,1,1,0,10'h3FF,'0,0, 0,0,D0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D0,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D0,0);
    add(0,0,0,0,10'h000,'0,1, 0,1,D2,0);
    add(0,0,0,0,10'h000,'0,1, 1,0,D2,0);
    // Both enables: treated as write, error pulse
    add(0,1,1,1,10'h010,D3,0, 0,0,D2,1);
    add(0,0,0,0,10'h000,'0,0, 0,0,D2,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D2,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D2,0);
    add(0,0,0,0,10'h000,'0,0, 1,0,D2,0);
    // No enable: error pulse, no accept
    add(0,1,0,0,10'h010,'0,0, 1,0,D2,1);
    add(0,0,0,0,10'h000,'0,0, 1,0,D2,0);
    // Read back 0x010
    add(0,1,1,0,10'h010,'0,0, 0,0,D2,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D2,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D2,0);
    add(0,0,0,0,10'h000,'0,0, 0,0,D2,0);
    add(0,0,0,0,10'h000,'0,1, 0,1,D3,0);
    add(0,0,0,0,10'h000,'0,1, 1,0,D3,0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rc);
      chk($sformatf("row%0d ready_mem", i), 128'(ready_mem), 128'(tbl[i].e_ready));
      chk($sformatf("row%0d valid_mem", i), 128'(valid_mem), 128'(tbl[i].e_valid));
      chk($sformatf("row%0d rdata_mem", i), rdata_mem, tbl[i].e_rdata);
      chk($sformatf("row%0d req_err", i), 128'(req_err), 128'(tbl[i].e_err));
    end

    // Commit A at 0x020, counting busy cycles
    cyc(0, 1, 0, 1, 10'h020, DA, 0);
    n = 0;
    while (!ready_mem && n < 20) begin idle(0); n++; end
    chk("writeA busy cycles", 128'(n), 128'd4);

    // Write B to 0x020, reset two edges after accept
    cyc(0, 1, 0, 1, 10'h020, DB, 0);
    idle(0);
    cyc(1, 0, 0, 0, 10'h000, '0, 0);
    chk("midrst ready_mem", 128'(ready_mem), 128'd1);
    chk("midrst valid_mem", 128'(valid_mem), 128'd0);
    chk("midrst rdata_mem", rdata_mem, 128'd0);
    chk("midrst req_err", 128'(req_err), 128'd0);
    cyc(1, 0, 0, 0, 10'h000, '0, 0);
    idle(0);
    idle(0);
    idle(0);
    chk("post-rst ready_mem", 128'(ready_mem), 128'd1);

    // Read 0x020: A must survive, latency 4
    cyc(0, 1, 1, 0, 10'h020, '0, 0);
    n = 0;
    while (!valid_mem && n < 20) begin idle(0); n++; end
    chk("readA latency", 128'(n), 128'd4);
    chk("readA rdata", rdata_mem, DA);
    idle(1);
    chk("readA release valid", 128'(valid_mem), 128'd0);
    chk("readA release ready", 128'(ready_mem), 128'd1);

    // Refill aborted by reset never presents data
    cyc(0, 1, 1, 0, 10'h005, '0, 0);
    idle(0);
    cyc(1, 0, 0, 0, 10'h000, '0, 0);
    for (int k = 0; k < 5; k++) idle(0);
    chk("abort rd valid_mem", 128'(valid_mem), 128'd0);
    chk("abort rd ready_mem", 128'(ready_mem), 128'd1);
    chk("abort rd rdata_mem", rdata_mem, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
